// File: rtl/mac_bank_acc.sv
// Multi-lane 3x3 convolution MAC bank that accumulates 2x2 output patches across
// first/last-framed input-channel beats, then requantises, applies ReLU and saturates.
module mac_bank_acc #(
    parameter int NUM_MAC = 12,
    parameter int DW      = 8,
    parameter int WW      = 8,
    parameter int ACC_W   = 28,
    parameter int OUT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         vld_i,
    input  logic                         first_i,
    input  logic                         last_i,
    input  logic [NUM_MAC*16*DW-1:0]     din_i,
    input  logic [NUM_MAC*9*WW-1:0]      weight_i,
    input  logic [4:0]                   shift_i,
    input  logic                         relu_en_i,
    output logic                         vld_o,
    output logic [NUM_MAC*4*OUT_W-1:0]   out_o,
    output logic                         busy_o,
    output logic                         ovf_o,
    output logic                         err_o
);

    localparam int PW   = DW + WW + 1;
    localparam int DOTW = PW + 4;
    // Wide enough that the rounding constant for any 5-bit shift cannot overflow.
    localparam int RW   = ((ACC_W > 32) ? ACC_W : 32) + 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [RW-1:0]    O_MAX   = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0]    O_MIN   = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t r_state, w_state_nxt;
    logic   w_accept, w_err;

    logic                    r_p1_vld, r_p1_first, r_p1_last, r_p1_relu;
    logic [4:0]              r_p1_shift;
    logic signed [DOTW-1:0]  r_p1_dot [NUM_MAC][4];
    logic signed [DOTW-1:0]  w_dot    [NUM_MAC][4];

    logic                    r_a_emit, r_a_relu;
    logic [4:0]              r_a_shift;
    logic signed [ACC_W-1:0] r_acc     [NUM_MAC][4];
    logic signed [ACC_W-1:0] w_acc_nxt [NUM_MAC][4];
    logic                    w_acc_sat;

    logic                    r_r_vld, r_r_relu;
    logic signed [RW-1:0]    r_rq [NUM_MAC][4];
    logic signed [RW-1:0]    w_rq [NUM_MAC][4];

    logic                         r_vld_o, r_ovf, r_err;
    logic [NUM_MAC*4*OUT_W-1:0]   r_out, w_out;
    logic                         w_out_sat;

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_err       = 1'b0;
        if (vld_i) begin
            if (first_i) begin
                w_accept    = 1'b1;
                w_state_nxt = last_i ? IDLE : ACCUM;
                w_err       = (r_state == ACCUM) && !last_i;
            end else if (r_state == ACCUM) begin
                w_accept    = 1'b1;
                w_state_nxt = last_i ? IDLE : ACCUM;
            end else begin
                w_err = 1'b1;
            end
        end
    end

    always_comb begin
        logic signed [PW-1:0] v_prod;
        v_prod = '0;
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int q = 0; q < 4; q++) begin
                w_dot[m][q] = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        v_prod = $signed({1'b0, din_i[m*16*DW + (((q/2)+i)*4 + (q%2)+j)*DW +: DW]})
                               * $signed(weight_i[m*9*WW + (i*3+j)*WW +: WW]);
                        w_dot[m][q] = w_dot[m][q] + DOTW'(v_prod);
                    end
                end
            end
        end
    end

    always_comb begin
        logic signed [ACC_W:0] v_sum;
        v_sum     = '0;
        w_acc_sat = 1'b0;
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int q = 0; q < 4; q++) begin
                v_sum = (ACC_W+1)'(r_acc[m][q]) + (ACC_W+1)'(r_p1_dot[m][q]);
                if (r_p1_first) begin
                    w_acc_nxt[m][q] = ACC_W'(r_p1_dot[m][q]);
                end else if (v_sum[ACC_W] != v_sum[ACC_W-1]) begin
                    w_acc_nxt[m][q] = v_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    w_acc_sat       = 1'b1;
                end else begin
                    w_acc_nxt[m][q] = v_sum[ACC_W-1:0];
                end
            end
        end
    end

    always_comb begin
        logic signed [RW-1:0] v_rnd;
        v_rnd = (r_a_shift != 5'd0) ? (RW'(1) << (r_a_shift - 5'd1)) : '0;
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int q = 0; q < 4; q++) begin
                w_rq[m][q] = (RW'(r_acc[m][q]) + v_rnd) >>> r_a_shift;
            end
        end
    end

    always_comb begin
        logic signed [RW-1:0] v_r;
        v_r       = '0;
        w_out     = '0;
        w_out_sat = 1'b0;
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int q = 0; q < 4; q++) begin
                v_r = r_rq[m][q];
                if (r_r_relu && v_r < 0) v_r = '0;
                if (v_r > O_MAX) begin
                    v_r       = O_MAX;
                    w_out_sat = 1'b1;
                end else if (v_r < O_MIN) begin
                    v_r       = O_MIN;
                    w_out_sat = 1'b1;
                end
                w_out[(m*4+q)*OUT_W +: OUT_W] = v_r[OUT_W-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so stage order never matters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_p1_vld   <= 1'b0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_relu  <= 1'b0;
            r_p1_shift <= '0;
            r_a_emit   <= 1'b0;
            r_a_relu   <= 1'b0;
            r_a_shift  <= '0;
            r_r_vld    <= 1'b0;
            r_r_relu   <= 1'b0;
            r_vld_o    <= 1'b0;
            r_out      <= '0;
            // NOTE: the per-lane arrays are reset too; a result must never expose stale sums after reset.
            for (int m = 0; m < NUM_MAC; m++) begin
                for (int q = 0; q < 4; q++) begin
                    r_p1_dot[m][q] <= '0;
                    r_acc[m][q]    <= '0;
                    r_rq[m][q]     <= '0;
                end
            end
        end else begin
            r_state  <= w_state_nxt;
            r_err    <= r_err | w_err;
            r_ovf    <= r_ovf | (r_p1_vld & w_acc_sat) | (r_r_vld & w_out_sat);

            r_p1_vld <= w_accept;
            if (w_accept) begin
                r_p1_first <= first_i;
                r_p1_last  <= last_i;
                r_p1_relu  <= relu_en_i;
                r_p1_shift <= shift_i;
                r_p1_dot   <= w_dot;
            end

            r_a_emit <= r_p1_vld & r_p1_last;
            if (r_p1_vld) r_acc <= w_acc_nxt;
            if (r_p1_vld && r_p1_last) begin
                r_a_shift <= r_p1_shift;
                r_a_relu  <= r_p1_relu;
            end

            r_r_vld <= r_a_emit;
            if (r_a_emit) begin
                r_rq     <= w_rq;
                r_r_relu <= r_a_relu;
            end

            r_vld_o <= r_r_vld;
            if (r_r_vld) r_out <= w_out;
        end
    end

    assign vld_o  = r_vld_o;
    assign out_o  = r_out;
    assign busy_o = (r_state == ACCUM);
    assign ovf_o  = r_ovf;
    assign err_o  = r_err;

endmodule

// File: tb/tb_mac_bank_acc.sv
// Directed bench for mac_bank_acc: a table of uniform-data frames plus hand-written
// sequences for spatial indexing, framing errors, back-to-back frames and async reset.
module tb_mac_bank_acc;

    localparam int NUM_MAC = 12;
    localparam int DW      = 8;
    localparam int WW      = 8;
    localparam int ACC_W   = 28;
    localparam int OUT_W   = 16;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        vld_i, first_i, last_i, relu_en_i;
    logic [NUM_MAC*16*DW-1:0]    din_i;
    logic [NUM_MAC*9*WW-1:0]     weight_i;
    logic [4:0]                  shift_i;
    logic                        vld_o, busy_o, ovf_o, err_o;
    logic [NUM_MAC*4*OUT_W-1:0]  out_o;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    mac_bank_acc #(.NUM_MAC(NUM_MAC), .DW(DW), .WW(WW), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .first_i(first_i), .last_i(last_i),
        .din_i(din_i), .weight_i(weight_i), .shift_i(shift_i), .relu_en_i(relu_en_i),
        .vld_o(vld_o), .out_o(out_o), .busy_o(busy_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Counts result pulses a little after each rising edge, clear of the negedge checks.
    always @(posedge clk) begin
        #2;
        if (vld_o) pulses++;
    end

    typedef struct {
        int d; int k; bit tap0; int beats; int shift; bit relu; int exp; bit exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_val(input int m, input int q);
        logic signed [OUT_W-1:0] v;
        v = out_o[(m*4+q)*OUT_W +: OUT_W];
        return int'(v);
    endfunction

    task automatic check_all(input string name, input int exp);
        int act;
        act = out_val(0, 0);
        for (int m = 0; m < NUM_MAC; m++)
            for (int q = 0; q < 4; q++)
                if (out_val(m, q) != exp) act = out_val(m, q);
        check(name, act, exp);
    endtask

    task automatic beat(input int d, input int k, input bit tap0, input bit f, input bit l,
                        input int sh, input bit relu);
        @(negedge clk);
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int p = 0; p < 16; p++) din_i[(m*16+p)*DW +: DW] = d[DW-1:0];
            for (int t = 0; t < 9; t++)  weight_i[(m*9+t)*WW +: WW] = (tap0 && t != 0) ? '0 : k[WW-1:0];
        end
        vld_i = 1'b1; first_i = f; last_i = l; shift_i = sh[4:0]; relu_en_i = relu;
    endtask

    task automatic idle();
        @(negedge clk);
        vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
    endtask

    // Called right after idle(): the last beat has just been sampled.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!vld_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0; vld_i = 1'b0; first_i = 1'b0; last_i = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    function automatic int exp_pat(input int m, input int q);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += (((q/2)+i)*4 + (q%2)+j + m) * ((i*3+j)*29 - 120 + m);
        return s;
    endfunction

    initial begin
        int lat, p0;
        din_i = '0; weight_i = '0; shift_i = '0; relu_en_i = 1'b0;
        vecs[0] = '{1,    1,    0, 1,  0, 0, 9,      0};
        vecs[1] = '{2,    -3,   0, 4,  0, 0, -216,   0};
        vecs[2] = '{2,    -3,   0, 4,  0, 1, 0,      0};
        vecs[3] = '{2,    -3,   0, 4,  3, 0, -27,    0};
        vecs[4] = '{125,  8,    1, 1,  4, 0, 63,     0};
        vecs[5] = '{3,    5,    0, 2,  1, 1, 135,    0};
        vecs[6] = '{255,  -1,   0, 1,  2, 0, -574,   0};
        vecs[7] = '{2,    -3,   0, 4,  4, 0, -13,    0};
        vecs[8] = '{255,  127,  0, 16, 0, 0, 32767,  1};
        vecs[9] = '{255,  -128, 0, 16, 0, 0, -32768, 1};

        do_reset();
        check("reset vld_o", vld_o, 0);
        check("reset out_o", (out_o == '0) ? 0 : 1, 0);
        check("reset busy_o", busy_o, 0);
        check("reset ovf_o", ovf_o, 0);
        check("reset err_o", err_o, 0);

        for (int v = 0; v < 10; v++) begin
            p0 = pulses;
            for (int b = 0; b < vecs[v].beats; b++)
                beat(vecs[v].d, vecs[v].k, vecs[v].tap0, b == 0, b == vecs[v].beats - 1,
                     vecs[v].shift, vecs[v].relu);
            idle();
            wait_result(lat);
            check($sformatf("vec%0d latency", v), lat, 3);
            check_all($sformatf("vec%0d out", v), vecs[v].exp);
            check($sformatf("vec%0d ovf", v), ovf_o, vecs[v].exp_ovf);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d vld pulses", v), pulses - p0, 1);
            check_all($sformatf("vec%0d out hold", v), vecs[v].exp);
            check($sformatf("vec%0d busy", v), busy_o, 0);
            check($sformatf("vec%0d err", v), err_o, 0);
        end

        // Four-beat frame: busy while open, a single result at the end.
        p0 = pulses;
        beat(2, -3, 0, 1, 0, 0, 0);
        beat(2, -3, 0, 0, 0, 0, 0);
        check("frame busy b1", busy_o, 1);
        beat(2, -3, 0, 0, 0, 0, 0);
        check("frame busy b2", busy_o, 1);
        beat(2, -3, 0, 0, 1, 0, 0);
        check("frame busy b3", busy_o, 1);
        check("frame no early vld", pulses - p0, 0);
        idle();
        check("frame busy after last", busy_o, 0);
        wait_result(lat);
        check("frame latency", lat, 3);
        check_all("frame out", -216);
        repeat (2) @(negedge clk);
        check("frame one pulse", pulses - p0, 1);

        // Distinct pixels and taps per lane exercise the window indexing.
        do_reset();
        @(negedge clk);
        for (int m = 0; m < NUM_MAC; m++) begin
            for (int p = 0; p < 16; p++) din_i[(m*16+p)*DW +: DW] = 8'(p + m);
            for (int t = 0; t < 9; t++)  weight_i[(m*9+t)*WW +: WW] = 8'(t*29 - 120 + m);
        end
        vld_i = 1'b1; first_i = 1'b1; last_i = 1'b1; shift_i = '0; relu_en_i = 1'b0;
        idle();
        wait_result(lat);
        check("pattern latency", lat, 3);
        for (int m = 0; m < NUM_MAC; m++)
            for (int q = 0; q < 4; q++)
                check($sformatf("pattern m%0d q%0d", m, q), out_val(m, q), exp_pat(m, q));
        check("pattern ovf", ovf_o, 0);

        // Back-to-back single-pass frames with no bubble.
        beat(1, 1, 0, 1, 1, 0, 0);
        beat(2, 1, 0, 1, 1, 0, 0);
        idle();
        wait_result(lat);
        check("b2b latency", lat, 2);
        check_all("b2b first out", 9);
        @(negedge clk);
        check("b2b second vld", vld_o, 1);
        check_all("b2b second out", 18);
        check("b2b err", err_o, 0);

        // Stray beat in IDLE is dropped and flagged.
        p0 = pulses;
        beat(5, 5, 0, 0, 1, 0, 0);
        idle();
        check("stray err", err_o, 1);
        check("stray busy", busy_o, 0);
        repeat (6) @(negedge clk);
        check("stray no vld", pulses - p0, 0);

        // A second first mid-frame restarts the sum.
        do_reset();
        p0 = pulses;
        beat(2, -3, 0, 1, 0, 0, 0);
        beat(2, -3, 0, 0, 0, 0, 0);
        beat(1, 1, 0, 1, 0, 0, 0);
        beat(1, 1, 0, 0, 1, 0, 0);
        check("restart err", err_o, 1);
        idle();
        wait_result(lat);
        check_all("restart out", 18);
        repeat (2) @(negedge clk);
        check("restart one pulse", pulses - p0, 1);

        // Reset asserted while a result is in flight loses it.
        p0 = pulses;
        beat(3, 3, 0, 1, 1, 0, 0);
        idle();
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check_all("areset out", 0);
        check("areset vld", vld_o, 0);
        check("areset busy", busy_o, 0);
        check("areset err", err_o, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        check("areset no pulse", pulses - p0, 0);
        check_all("areset out stays", 0);
        beat(1, 1, 0, 1, 1, 0, 0);
        idle();
        wait_result(lat);
        check("post-reset latency", lat, 3);
        check_all("post-reset out", 9);

        // Long negative frame drives the accumulator into saturation.
        do_reset();
        for (int b = 0; b < 470; b++) begin
            beat(255, -128, 0, b == 0, b == 469, 12, 0);
            if (b == 400) check("acc ovf not yet", ovf_o, 0);
        end
        idle();
        wait_result(lat);
        check_all("acc sat out", -32768);
        check("acc sat ovf", ovf_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
